// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding modes, corner cases, status bit map, result bundle.
package fpu_pkg;

    typedef enum logic [2:0] {
        RND_NE,
        RND_TZ,
        RND_UP,
        RND_DN,
        RND_MM
    } round_t;

    typedef enum logic [2:0] {
        CC_NONE,
        CC_ZERO,
        CC_INF,
        CC_NAN,
        CC_DENORM
    } corner_case_t;

    localparam int STAT_ZERO     = 0;
    localparam int STAT_INF      = 1;
    localparam int STAT_NAN      = 2;
    localparam int STAT_TINY     = 3;
    localparam int STAT_HUGE     = 4;
    localparam int STAT_INEXACT  = 5;
    localparam int STAT_W        = 8;
    localparam int STAT_STICKY_W = 6;

    typedef struct packed {
        logic [31:0]       z;
        logic [STAT_W-1:0] status;
    } fp_result_t;

    // Reserved status bits [7:6] never reach the sticky summary.
    function automatic logic [STAT_STICKY_W-1:0] sticky_bits(
        input logic [STAT_W-1:0] status
    );
        return status[STAT_STICKY_W-1:0];
    endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
module fp_sync_fifo
    import fpu_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fp_mult_result_buffer.sv
// Result buffer behind fp_mult_top: FWFT FIFO, sticky flags, counter, irq.
// Optional registered interrupt enabled by defining FP_RESULT_BUF_IRQ_EN.
module fp_mult_result_buffer
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_z,
    input  logic [7:0]                 in_status,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_z,
    output logic [7:0]                 out_status,
    output logic [$clog2(DEPTH):0]     level,
    output logic [STAT_STICKY_W-1:0]   sticky,
    input  logic                       sticky_clr,
    output logic [CNT_W-1:0]           result_cnt,
    input  logic [STAT_STICKY_W-1:0]   irq_mask,
    output logic                       irq
);

    fp_result_t                 wr_entry;
    fp_result_t                 rd_entry;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic [STAT_STICKY_W-1:0]   sticky_next;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign wr_entry.z      = in_z;
    assign wr_entry.status = in_status;
    assign out_z           = rd_entry.z;
    assign out_status      = rd_entry.status;

    fp_sync_fifo #(
        .WIDTH ($bits(fp_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // A clear and a push in the same cycle keep only the new flags.
    always_comb begin
        sticky_next = sticky_clr ? '0 : sticky;
        if (push) begin
            sticky_next = sticky_next | sticky_bits(in_status);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky     <= '0;
            result_cnt <= '0;
        end else begin
            sticky <= sticky_next;
            if (push && (result_cnt != '1)) begin
                result_cnt <= result_cnt + CNT_W'(1);
            end
        end
    end

`ifdef FP_RESULT_BUF_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(sticky_next & irq_mask);
        end
    end
`else
    logic unused_irq_mask;
    assign unused_irq_mask = ^irq_mask;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mult_result_buffer.sv
// Randomized and directed check of fp_mult_result_buffer against a queue model.
module tb_fp_mult_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 5;
`ifdef FP_RESULT_BUF_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_z = '0;
    logic [7:0]  in_status = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z;
    logic [7:0]  out_status;
    logic [2:0]  level;
    logic [5:0]  sticky;
    logic        sticky_clr = 1'b0;
    logic [CNT_W-1:0] result_cnt;
    logic [5:0]  irq_mask = '0;
    logic        irq;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    typedef struct {
        logic [31:0] z;
        logic [7:0]  s;
    } ent_t;

    ent_t        q[$];
    logic [5:0]  m_sticky = '0;
    int          m_cnt = 0;
    logic        m_irq = 1'b0;

    fp_mult_result_buffer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_z       (in_z),
        .in_status  (in_status),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_status (out_status),
        .level      (level),
        .sticky     (sticky),
        .sticky_clr (sticky_clr),
        .result_cnt (result_cnt),
        .irq_mask   (irq_mask),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is just a queue of accepted entries.
    always @(posedge clk) begin
        bit         do_push;
        bit         do_pop;
        logic [5:0] nxt;
        if (rst) begin
            q.delete();
            m_sticky = '0;
            m_cnt    = 0;
            m_irq    = 1'b0;
        end else begin
            do_push = in_valid && (q.size() < DEPTH);
            do_pop  = out_ready && (q.size() > 0);
            nxt = (sticky_clr ? 6'h00 : m_sticky)
                | (do_push ? in_status[5:0] : 6'h00);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{z: in_z, s: in_status});
            if (do_push && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_sticky = nxt;
            m_irq    = IRQ_ON ? |(nxt & irq_mask) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", in_ready, q.size() < DEPTH);
            check("out_valid", out_valid, q.size() > 0);
            check("level", level, q.size());
            check("out_z", out_z, q.size() > 0 ? q[0].z : 32'h0);
            check("out_status", out_status, q.size() > 0 ? q[0].s : 8'h0);
            check("sticky", sticky, m_sticky);
            check("result_cnt", result_cnt, m_cnt);
            check("irq", irq, m_irq);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(logic [31:0] z, logic [7:0] s);
        in_valid  = 1'b1;
        in_z      = z;
        in_status = s;
        step();
    endtask

    logic [31:0] fill_z [4];
    logic [7:0]  fill_s [4];

    initial begin
        fill_z = '{32'h3F800000, 32'h40000000, 32'h7F800000, 32'h7FC00000};
        fill_s = '{8'h00, 8'h00, 8'h02, 8'h04};

        step();
        step();
        cmp_en = 1'b1;
        rst = 1'b0;
        check("rst_level", level, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_z", out_z, 0);
        check("rst_cnt", result_cnt, 0);

        for (int i = 0; i < 4; i++) push_one(fill_z[i], fill_s[i]);
        check("fill_in_ready", in_ready, 0);
        check("fill_level", level, 4);
        push_one(32'h12345678, 8'h10);
        check("fill5_level", level, 4);
        check("fill5_cnt", result_cnt, 4);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_z", out_z, fill_z[i]);
            step();
        end
        check("drain_out_valid", out_valid, 0);
        check("drain_level", level, 0);
        check("sticky_06", sticky, 6'h06);

        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("sticky_clr", sticky, 6'h00);
        push_one(32'h1, 8'h20);
        push_one(32'h2, 8'h08);
        in_valid = 1'b0;
        check("sticky_28", sticky, 6'h28);
        sticky_clr = 1'b1;
        push_one(32'h3, 8'h01);
        sticky_clr = 1'b0;
        in_valid   = 1'b0;
        check("sticky_01", sticky, 6'h01);

        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        push_one(32'h100, 8'h00);
        push_one(32'h101, 8'h00);
        check("pp_level0", level, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_one(32'h102 + i, 8'h00);
            check("pp_level", level, 2);
            check("pp_z", out_z, 32'h100 + i + 1);
        end

        out_ready = 1'b0;
        push_one(32'h200, 8'h10);
        check("mid_level3", level, 3);
        rst       = 1'b1;
        out_ready = 1'b1;
        push_one(32'h201, 8'h3F);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mid_level", level, 0);
        check("mid_out_valid", out_valid, 0);
        check("mid_sticky", sticky, 0);
        check("mid_cnt", result_cnt, 0);

        irq_mask = 6'h04;
        push_one(32'h7FC00000, 8'h04);
        in_valid = 1'b0;
        check("irq_set", irq, IRQ_ON);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("irq_clr", irq, 0);

        for (int n = 0; n < 3000; n++) begin
            in_valid   = ($urandom_range(0, 99) < 60);
            out_ready  = ($urandom_range(0, 99) < 50);
            sticky_clr = ($urandom_range(0, 99) < 5);
            rst        = ($urandom_range(0, 999) < 4);
            in_z       = $urandom;
            in_status  = 8'($urandom);
            if ($urandom_range(0, 99) < 3) irq_mask = 6'($urandom);
            step();
        end
        rst        = 1'b0;
        in_valid   = 1'b0;
        sticky_clr = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
